if_fetch: RTL and testbench

//   Instruction-fetch stage. Owns the PC, issues word fetches to instruction memory over a
//   req/gnt/rvalid handshake, and buffers returned words in a small in-order FIFO.

---
 rtl/if_fetch.sv | 159 +++++++++++++++
 tb/tb_if_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC owner, imem req/gnt/rvalid master, in-order
// response FIFO and registered {pc, inst} output toward decode.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;
   typedef enum logic {S_RUN, S_DRAIN} state_e;

   localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   cnt_t        out_cnt_q, out_cnt_d;
   cnt_t        drop_cnt_q, drop_cnt_d;
   cnt_t        fifo_cnt_q, fifo_cnt_d;
   ptr_t        tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   ptr_t        f_wr_q, f_wr_d, f_rd_q, f_rd_d;
   logic [31:0] opc_q, opc_d, oinst_q, oinst_d;
   logic        oval_q, oval_d;

   logic [31:0] tag_q   [DEPTH];
   logic [31:0] fpc_q   [DEPTH];
   logic [31:0] finst_q [DEPTH];

   logic [CW:0] occ;
   logic        issue, accept, bypass, push, pop, fifo_empty;
   logic [31:0] tag_head;

   assign occ        = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
   assign imem_req_o = !rst && (state_q == S_RUN) && !flush_i && (occ < OCC_MAX);
   assign imem_addr_o = pc_q;
   assign issue      = imem_req_o && imem_gnt_i;
   // drop_cnt is non-zero exactly while draining, so this also rejects stale data
   assign accept     = imem_rvalid_i && !flush_i && (drop_cnt_q == '0);
   assign fifo_empty = (fifo_cnt_q == '0);
   assign bypass     = accept && fifo_empty && !stall_i;
   assign push       = accept && !bypass;
   assign pop        = !flush_i && !stall_i && !fifo_empty;
   assign tag_head   = tag_q[tag_rd_q];

   assign pc_o         = opc_q;
   assign inst_o       = oinst_q;
   assign inst_valid_o = oval_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      out_cnt_d  = out_cnt_q + cnt_t'(issue) - cnt_t'(imem_rvalid_i);
      drop_cnt_d = drop_cnt_q;
      fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
      tag_wr_d   = issue  ? ptr_inc(tag_wr_q) : tag_wr_q;
      tag_rd_d   = accept ? ptr_inc(tag_rd_q) : tag_rd_q;
      f_wr_d     = push   ? ptr_inc(f_wr_q)   : f_wr_q;
      f_rd_d     = pop    ? ptr_inc(f_rd_q)   : f_rd_q;
      opc_d      = opc_q;
      oinst_d    = oinst_q;
      oval_d     = oval_q;

      if (issue) pc_d = pc_q + 32'd4;

      if (!stall_i) begin
         if (!fifo_empty) begin
            opc_d   = fpc_q[f_rd_q];
            oinst_d = finst_q[f_rd_q];
            oval_d  = 1'b1;
         end else if (bypass) begin
            opc_d   = tag_head;
            oinst_d = imem_rdata_i;
            oval_d  = 1'b1;
         end else begin
            opc_d   = '0;
            oinst_d = '0;
            oval_d  = 1'b0;
         end
      end

      if (flush_i) begin
         // out_cnt equals drop_cnt while draining, so one formula covers both states
         pc_d       = flush_pc_i & 32'hFFFF_FFFC;
         drop_cnt_d = out_cnt_q - cnt_t'(imem_rvalid_i);
         out_cnt_d  = drop_cnt_d;
         fifo_cnt_d = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
         f_wr_d     = '0;
         f_rd_d     = '0;
         opc_d      = '0;
         oinst_d    = '0;
         oval_d     = 1'b0;
         state_d    = (drop_cnt_d != '0) ? S_DRAIN : S_RUN;
      end else if (state_q == S_DRAIN) begin
         if (imem_rvalid_i) drop_cnt_d = drop_cnt_q - cnt_t'(1);
         if (drop_cnt_d == '0) state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RUN;
         pc_q       <= RESET_PC;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         fifo_cnt_q <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         f_wr_q     <= '0;
         f_rd_q     <= '0;
         opc_q      <= '0;
         oinst_q    <= '0;
         oval_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         f_wr_q     <= f_wr_d;
         f_rd_q     <= f_rd_d;
         opc_q      <= opc_d;
         oinst_q    <= oinst_d;
         oval_q     <= oval_d;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) tag_q[tag_wr_q] <= pc_q;
      if (push) begin
         fpc_q[f_wr_q]   <= tag_head;
         finst_q[f_wr_q] <= imem_rdata_i;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: memory model with random latency/grant, issue-order
// expectation queue cleared on redirect/reset, independent output monitor.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] XORK   = 32'hA5A5_0000;

   logic        clk, rst, stall_i, flush_i, imem_req_o, imem_gnt_i, imem_rvalid_i, inst_valid_o;
   logic [31:0] flush_pc_i, imem_addr_o, imem_rdata_i, pc_o, inst_o;

   if_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
   );

   typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

   mreq_t       mq[$];
   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc_n = 0;
   int unsigned lat_min = 1, lat_max = 1, rv_pct = 100;
   logic [31:0] model_pc = RST_PC;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wait_issue(input string nm, output logic [31:0] a);
      a = 'x;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (imem_req_o && imem_gnt_i) begin a = imem_addr_o; return; end
      end
      checks++; failures++;
      $display("FAIL %s: got no issue in 60 cycles, expected an issue", nm);
   endtask

   task automatic wait_valid(input string nm, output logic [31:0] p);
      p = 'x;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (inst_valid_o) begin p = pc_o; return; end
      end
      checks++; failures++;
      $display("FAIL %s: got no valid output in 60 cycles, expected one", nm);
   endtask

   // Memory model and expectation producer: responses in issue order, >=1 cycle later.
   initial begin : mem_proc
      forever begin
         @(posedge clk); #1;
         cyc_n++;
         if (!rst && mq.size() > 0 && mq[0].due <= cyc_n && $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mq[0].addr ^ XORK;
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
         end
         @(negedge clk); #1;
         if (rst) begin
            mq.delete();
            exp_q.delete();
            model_pc = RST_PC;
         end else begin
            if (imem_rvalid_i) void'(mq.pop_front());
            if (flush_i) begin
               exp_q.delete();
               model_pc = flush_pc_i & 32'hFFFF_FFFC;
            end
            if (imem_req_o && imem_gnt_i) begin
               chk("issue_addr", imem_addr_o, model_pc);
               mq.push_back('{addr: model_pc, due: cyc_n + $urandom_range(lat_min, lat_max)});
               exp_q.push_back('{pc: model_pc, inst: model_pc ^ XORK});
               model_pc = model_pc + 32'd4;
            end
         end
      end
   end

   // Output monitor: kind 0 = register loaded last edge, 1 = held, 2 = bubbled.
   initial begin : monitor
      int          kind;
      logic [31:0] hpc, hinst;
      logic        hv;
      exp_t        e;
      kind = 2; hpc = '0; hinst = '0; hv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_pc_o", pc_o, 32'h0);
            chk("reset_inst_o", inst_o, 32'h0);
            chk("reset_valid", 32'(inst_valid_o), 32'h0);
         end else if (kind == 0) begin
            if (inst_valid_o) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL sb_unexpected: got pc %h, expected no instruction", pc_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_pc", pc_o, e.pc);
                  chk("sb_inst", inst_o, e.inst);
               end
            end else begin
               chk("bubble_pc", pc_o, 32'h0);
               chk("bubble_inst", inst_o, 32'h0);
            end
         end else if (kind == 1) begin
            chk("hold_pc", pc_o, hpc);
            chk("hold_inst", inst_o, hinst);
            chk("hold_valid", 32'(inst_valid_o), 32'(hv));
         end else begin
            chk("flush_bubble_valid", 32'(inst_valid_o), 32'h0);
            chk("flush_bubble_pc", pc_o, 32'h0);
         end
         kind = (rst || flush_i) ? 2 : (stall_i ? 1 : 0);
         hpc = pc_o; hinst = inst_o; hv = inst_valid_o;
      end
   end

   initial begin : stim
      logic [31:0] a, p;
      int          w;
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0; imem_gnt_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req_o), 32'h0);
      chk("rst_addr", imem_addr_o, RST_PC);

      // Back-to-back stream after reset
      cyc(); rst = 1'b0; imem_gnt_i = 1'b1;
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            chk("t1_valid", 32'(inst_valid_o), 32'h1);
            chk("t1_pc", pc_o, 32'(4 * (k - 2)));
         end
      end

      // Stall five cycles: request must back off once the two slots fill
      for (int s = 0; s < 5; s++) begin
         cyc(); stall_i = 1'b1;
         @(negedge clk);
         if (s >= 2) chk("t2_req_drop", 32'(imem_req_o), 32'h0);
      end
      cyc(); stall_i = 1'b0;
      repeat (8) cyc();

      // Grant withheld: request and address held
      for (int g = 0; g < 3; g++) begin
         cyc(); imem_gnt_i = 1'b0;
         @(negedge clk);
         chk("t4_req_held", 32'(imem_req_o), 32'h1);
         chk("t4_addr_held", imem_addr_o, model_pc);
      end
      cyc(); imem_gnt_i = 1'b1;
      repeat (6) cyc();

      // Redirect with two outstanding fetches
      lat_min = 4; lat_max = 4;
      repeat (4) cyc();
      cyc(); flush_i = 1'b1; flush_pc_i = 32'h0000_0103;
      @(negedge clk);
      chk("t3_req_in_flush", 32'(imem_req_o), 32'h0);
      cyc(); flush_i = 1'b0;
      wait_issue("t3_issue", a);
      chk("t3_issue_addr", a, 32'h0000_0100);
      wait_valid("t3_valid", p);
      chk("t3_first_pc", p, 32'h0000_0100);
      lat_min = 1; lat_max = 1;
      repeat (10) cyc();

      // Flush + stall + response in the same cycle
      cyc(); stall_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h0000_2000;
      cyc(); stall_i = 1'b0; flush_i = 1'b0;
      wait_valid("t6_valid", p);
      chk("t6_first_pc", p, 32'h0000_2000);
      repeat (4) cyc();

      // Asynchronous reset mid-cycle while output valid
      @(negedge clk);
      chk("t5_pre_valid", 32'(inst_valid_o), 32'h1);
      @(posedge clk); #3; rst = 1'b1;
      #1;
      chk("t5_async_pc", pc_o, 32'h0);
      chk("t5_async_inst", inst_o, 32'h0);
      chk("t5_async_valid", 32'(inst_valid_o), 32'h0);
      cyc(); cyc(); rst = 1'b0;
      wait_issue("t5_refetch", a);
      chk("t5_refetch_addr", a, RST_PC);
      repeat (4) cyc();

      // PC wrap
      cyc(); flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFE;
      cyc(); flush_i = 1'b0;
      wait_issue("t7_issue0", a);
      chk("t7_addr_top", a, 32'hFFFF_FFFC);
      wait_issue("t7_issue1", a);
      chk("t7_addr_wrap", a, 32'h0000_0000);
      repeat (4) cyc();

      // Randomised traffic
      for (int r = 0; r < 600; r++) begin
         if (r % 100 == 0) begin
            lat_max = $urandom_range(1, 4);
            rv_pct  = $urandom_range(50, 100);
         end
         cyc();
         stall_i    = ($urandom_range(0, 3) == 0);
         imem_gnt_i = ($urandom_range(0, 3) != 0);
         flush_i    = ($urandom_range(0, 31) == 0);
         flush_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      end

      // Drain: every issued and unflushed fetch must eventually appear
      cyc(); stall_i = 1'b0; flush_i = 1'b0; imem_gnt_i = 1'b0; rv_pct = 100;
      w = 0;
      while ((exp_q.size() != 0 || mq.size() != 0) && w < 80) begin
         cyc(); w++;
      end
      @(negedge clk);
      chk("drain_exp_empty", 32'(exp_q.size()), 32'h0);
      chk("drain_mem_empty", 32'(mq.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
